// File: rtl/axo_debug_regs.sv
// Debug register bank behind the I2C debug slave.
// Decodes the byte-wide xrd bus and holds the per-hart halt/resume requests and
// the DATA0 buffer. A small FSM runs abstract commands that read or write hart
// GPRs over the acc_* request/ack port.
module axo_debug_regs #(
    parameter int unsigned NHARTS  = 2,
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned TBITS   = 10
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [31:0]       xrd_hart,
    output logic              xrd_present,
    input  logic [15:0]       xrd_addr,
    inout  wire logic [7:0]   xrd_data,
    input  logic              xrd_re,
    input  logic              xrd_we,
    output logic [NHARTS-1:0] halt_req,
    output logic [NHARTS-1:0] resume_req,
    input  logic [NHARTS-1:0] halted,
    output logic              acc_req,
    output logic [31:0]       acc_hart,
    output logic              acc_we,
    output logic [4:0]        acc_regno,
    output logic [31:0]       acc_wdata,
    input  logic              acc_ack,
    input  logic [31:0]       acc_rdata
);

    localparam int unsigned HW = (NHARTS > 1) ? $clog2(NHARTS) : 1;
    localparam logic [31:0] ID_VALUE = 32'h41584F31;

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e            state_q;
    logic [TBITS-1:0]  timer_q;
    logic [31:0]       data0_q;
    logic [4:0]        cmd_regno_q;
    logic              cmd_write_q;
    logic              cmderr_q;

    logic [HW-1:0]     hart_idx;
    logic              busy;
    logic              wr_en;
    logic [7:0]        wdata;
    logic [7:0]        rd_byte;
    logic              status_wr;
    logic              ctrl_wr;
    logic              data0_wr;
    logic              regno_wr;
    logic              flags_wr;
    logic              go_wr;

    // hart_idx is only meaningful while xrd_present is high
    assign xrd_present = (xrd_hart < 32'(NHARTS));
    assign hart_idx    = xrd_hart[HW-1:0];
    assign busy        = (state_q == StAccess);
    assign wdata       = xrd_data;

    // Write strobes; writes to absent harts are dropped here
    assign wr_en     = xrd_we && xrd_present;
    assign status_wr = wr_en && (xrd_addr == 16'h0004);
    assign ctrl_wr   = wr_en && (xrd_addr == 16'h0008);
    assign data0_wr  = wr_en && (xrd_addr[15:2] == 14'h0004);
    assign regno_wr  = wr_en && (xrd_addr == 16'h0014);
    assign flags_wr  = wr_en && (xrd_addr == 16'h0015);
    assign go_wr     = wr_en && (xrd_addr == 16'h0017);

    // Combinational read mux; absent harts and unmapped addresses read as zero
    always_comb begin
        rd_byte = 8'h00;
        if (xrd_present) begin
            case (xrd_addr)
                16'h0000: rd_byte = ID_VALUE[7:0];
                16'h0001: rd_byte = ID_VALUE[15:8];
                16'h0002: rd_byte = ID_VALUE[23:16];
                16'h0003: rd_byte = ID_VALUE[31:24];
                16'h0004: rd_byte = {3'b000, busy, cmderr_q, resume_req[hart_idx],
                                     halt_req[hart_idx], halted[hart_idx]};
                16'h0010: rd_byte = data0_q[7:0];
                16'h0011: rd_byte = data0_q[15:8];
                16'h0012: rd_byte = data0_q[23:16];
                16'h0013: rd_byte = data0_q[31:24];
                16'h0014: rd_byte = {3'b000, cmd_regno_q};
                16'h0015: rd_byte = {7'b0000000, cmd_write_q};
                default:  rd_byte = 8'h00;
            endcase
        end
    end

    // A simultaneous write strobe takes the bus, so the bank stays off it
    assign xrd_data = (xrd_re && !xrd_we) ? rd_byte : 8'bzzzz_zzzz;

    // Per-hart halt/resume request levels
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            halt_req   <= '0;
            resume_req <= '0;
        end else begin
            for (int unsigned h = 0; h < NHARTS; h++) begin
                if (resume_req[h] && !halted[h]) begin
                    resume_req[h] <= 1'b0;
                end
                // A fresh request on this hart overrides the auto-clear above
                if (ctrl_wr && (hart_idx == HW'(h))) begin
                    if (wdata[1]) begin
                        halt_req[h]   <= 1'b0;
                        resume_req[h] <= 1'b1;
                    end else if (wdata[0]) begin
                        halt_req[h]   <= 1'b1;
                        resume_req[h] <= 1'b0;
                    end
                end
            end
        end
    end

    // Command registers, DATA0, cmderr and the abstract-command FSM
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            data0_q     <= '0;
            cmd_regno_q <= '0;
            cmd_write_q <= 1'b0;
            cmderr_q    <= 1'b0;
            acc_req     <= 1'b0;
            acc_hart    <= '0;
            acc_we      <= 1'b0;
            acc_regno   <= '0;
            acc_wdata   <= '0;
        end else begin
            // Clear first so any error raised on this same edge sticks
            if (status_wr && wdata[3]) begin
                cmderr_q <= 1'b0;
            end
            if (data0_wr) begin
                if (busy) begin
                    cmderr_q <= 1'b1;
                end else begin
                    data0_q[{xrd_addr[1:0], 3'b000} +: 8] <= wdata;
                end
            end
            if (regno_wr && !busy) begin
                cmd_regno_q <= wdata[4:0];
            end
            if (flags_wr && !busy) begin
                cmd_write_q <= wdata[0];
            end

            case (state_q)
                StIdle: begin
                    if (go_wr && !cmderr_q) begin
                        if (!xrd_present || !halted[hart_idx]) begin
                            cmderr_q <= 1'b1;
                        end else begin
                            acc_hart  <= xrd_hart;
                            acc_we    <= cmd_write_q;
                            acc_regno <= cmd_regno_q;
                            acc_wdata <= data0_q;
                            acc_req   <= 1'b1;
                            timer_q   <= '0;
                            state_q   <= StAccess;
                        end
                    end
                end
                StAccess: begin
                    if (go_wr) begin
                        cmderr_q <= 1'b1;
                    end
                    if (acc_ack) begin
                        acc_req <= 1'b0;
                        if (!acc_we) begin
                            data0_q <= acc_rdata;
                        end
                        state_q <= StIdle;
                    end else begin
                        timer_q <= timer_q + TBITS'(1);
                        // Abort on the edge where the timer reaches TIMEOUT
                        if (timer_q == TBITS'(TIMEOUT - 1)) begin
                            acc_req  <= 1'b0;
                            cmderr_q <= 1'b1;
                            state_q  <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/axo_debug_regs.md
Name: axo_debug_regs

Overview:
Debug register bank directly downstream of the I²C debug slave; consumes its byte-wide xrd bus (hart select, 16-bit address, 8-bit data, re/we strobes). Holds per-hart halt/resume requests and a 32-bit data buffer, and runs an abstract-command FSM that reads and writes hart GPRs through a request/ack port. One instance serves all harts.

Parameters:
NHARTS, 2, number of harts; valid hart indices are 0..NHARTS-1.
TIMEOUT, 1023, clock cycles a GPR access waits for acc_ack before aborting.
TBITS, 10, width of the timeout counter; must satisfy TIMEOUT < 2^TBITS.

Ports:
clock  in  1  ungated core clock; all state changes on its rising edge.
reset_n  in  1  asynchronous active-low reset.
xrd_hart  in  32  selected hart index.
xrd_present  out  1  combinational: 1 when xrd_hart < NHARTS.
xrd_addr  in  16  debug register byte address.
xrd_data  inout  8  debug data; driven only while xrd_re=1, otherwise high-Z.
xrd_re  in  1  read strobe.
xrd_we  in  1  write strobe.
halt_req  out  NHARTS  per-hart halt request level.
resume_req  out  NHARTS  per-hart resume request.
halted  in  NHARTS  per-hart halted status.
acc_req  out  1  GPR access request.
acc_hart  out  32  hart index for the access, latched at launch.
acc_we  out  1  1=write GPR, 0=read GPR.
acc_regno  out  5  GPR number.
acc_wdata  out  32  write data (data0 at launch).
acc_ack  in  1  access complete, single-cycle pulse.
acc_rdata  in  32  read data, valid when acc_ack=1.

Behaviour:
- Reset: halt_req=0, resume_req=0, acc_req=0, acc_we=0, acc_regno=0, acc_hart=0, acc_wdata=0, data0=0, cmderr=0, FSM=IDLE, timer=0. xrd_data is high-Z.
- Reads are combinational: xrd_data reflects the addressed byte in the same cycle xrd_re=1. Writes take effect on the rising edge where xrd_we=1. If re and we are asserted together, we wins and xrd_data stays high-Z.
- Accesses with xrd_present=0: reads return 0x00, writes are ignored. Unmapped addresses: reads return 0x00, writes are ignored.
- Register map (little-endian byte lanes):
  - 0x0000-0x0003 ID, read-only, 0x41584F31.
  - 0x0004 STATUS, read-only except bit3:
    - bit0 halted[hart]
    - bit1 halt_req[hart]
    - bit2 resume_req[hart]
    - bit3 cmderr; write 1 to clear
    - bit4 busy (FSM != IDLE)
  - 0x0008 CONTROL, write-only:
    - bit0 sets halt_req[hart].
    - bit1 clears halt_req[hart] and sets resume_req[hart].
    - bit0 and bit1 both set: bit1 wins.
  - 0x0010-0x0013 DATA0, read/write. Writes while busy are ignored and set cmderr.
  - 0x0014 CMD_REGNO, bits[4:0].
  - 0x0015 CMD_FLAGS, bit0 = write.
  - 0x0017 CMD_GO: a write of any value launches a command.
- resume_req[h] stays high until halted[h]=0 is sampled, then clears on the next edge. A new halt request on that hart also clears it.
- FSM states IDLE, ACCESS:
  - IDLE, GO written:
    - busy already: not possible in IDLE.
    - cmderr=1: command ignored.
    - hart not present, or halted[hart]=0: cmderr set, stay IDLE.
    - otherwise latch acc_hart, acc_we, acc_regno, acc_wdata=data0; set acc_req=1; timer=0; go to ACCESS.
  - ACCESS:
    - acc_req held high, all acc_* outputs stable.
    - acc_ack=1: acc_req=0. If acc_we=0, data0 takes acc_rdata on the same edge. Go to IDLE. Busy drops the cycle after ack.
    - timer reaches TIMEOUT without ack: acc_req=0, cmderr=1, go to IDLE, data0 unchanged.
    - GO written while in ACCESS: ignored, cmderr set.
    - acc_ack while in IDLE: ignored.
- Writes to CMD_REGNO/CMD_FLAGS while busy are ignored. acc_* outputs come only from latched values, never from live CMD registers.
- Async reset mid-access: acc_req drops immediately, FSM returns to IDLE.
- Timer is TBITS wide, counts only in ACCESS, and never wraps (TIMEOUT < 2^TBITS).

Test Plan:
- Reset, then read 0x0000..0x0003 with hart 0 -> 0x31, 0x4F, 0x58, 0x41; xrd_present=1; all request outputs 0.
- hart=1, write 0x0008=0x01 -> halt_req=2'b10. Drive halted[1]=1, read 0x0004 -> 0x03. Write 0x0008=0x02 -> halt_req[1]=0, resume_req[1]=1. Drop halted[1] -> resume_req[1] clears one cycle later.
- hart 0 halted; write DATA0=0xDEADBEEF, REGNO=5, FLAGS=1, GO -> acc_req=1, acc_we=1, acc_regno=5, acc_wdata=0xDEADBEEF. Ack after 3 cycles -> busy=0, cmderr=0.
- Read of x7 with acc_rdata=0x12345678 -> DATA0 bytes read back as 0x78, 0x56, 0x34, 0x12.
- GO while hart not halted -> cmderr=1, acc_req stays 0. Second GO -> ignored. Write 0x0004=0x08 -> cmderr=0.
- TIMEOUT=15 with no ack -> acc_req drops after 15 cycles, cmderr=1. hart=5 with NHARTS=2 -> xrd_present=0, reads 0x00. Assert reset_n=0 mid-ACCESS -> acc_req=0 asynchronously.
